// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for RV32M
//               DIV/DIVU/REM/REMU. Holds the front of the pipeline via a
//               combinational stall while a divide is in flight.
//               Divide-by-zero and signed overflow complete in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               c_CW       = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0]  c_CNT_INIT = c_CW'(WIDTH);
    localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
    localparam logic [WIDTH-1:0] c_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_result;

    // Operand preparation on the accept cycle
    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_res;

    assign w_accept   = (r_state == c_IDLE) && start && !flush;
    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & a[WIDTH-1];
    assign w_b_neg    = w_signed & b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_div0     = (b == '0);
    assign w_ovf      = w_signed && (a == c_MIN) && (&b);
    assign w_fast     = w_div0 | w_ovf;
    // b==0: q=all ones, r=a. Overflow: q=a (most negative), r=0.
    assign w_fast_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // One restoring step: shift {rem, dividend} left and trial-subtract
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_calc_res;

    assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign w_qbit     = ~w_trial[WIDTH];
    assign w_rem_nxt  = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_qbit};
    assign w_last     = (r_cnt == c_CNT_ONE);
    // Truncating division: quotient sign from operand signs, remainder from dividend
    assign w_calc_res = r_is_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                 : (r_neg_q ? -w_quo_nxt : w_quo_nxt);

    assign stall  = w_accept || (r_state == c_CALC);
    assign done   = (r_state == c_DONE);
    assign result = r_result;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush wins over start and over completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_fast ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (flush) begin
                    w_next_state = c_IDLE;
                end else if (w_last) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, load result on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_quo    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_rem    <= '0;
                        r_cnt    <= c_CNT_INIT;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                        end
                    end
                end
                c_CALC: begin
                    if (!flush) begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (w_last) begin
                            r_result <= w_calc_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
